// File: rtl/regincr_arb_pkg.sv
// Shared types and helpers for the round-robin registered-incrementer arbiter.
//   reqid_t    : requester tag carried down the pipeline
//   REQ0/REQ1  : tag values for the two requesters
//   NUM_REQ    : number of requesters sharing the pipeline
//   ptr_width  : index width for a buffer of n entries (never less than 1)
package regincr_arb_pkg;

  typedef logic [0:0] reqid_t;

  localparam reqid_t REQ0 = 1'b0;
  localparam reqid_t REQ1 = 1'b1;

  localparam int unsigned NUM_REQ = 2;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regincr_pipe_arbiter_if.sv
// One val/rdy channel carrying a p_bitwidth operand or result.
//   val : producer has a message      (master -> slave)
//   msg : message payload             (master -> slave)
//   rdy : consumer can take a message (slave -> master)
interface regincr_pipe_arbiter_if #(
  parameter int unsigned p_bitwidth = 8
);

  logic                  val;
  logic                  rdy;
  logic [p_bitwidth-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);

endinterface

// File: rtl/regincr_resp_fifo.sv
// Per-requester response buffer (circular, p_depth entries).
//   clk, reset     : clock, asynchronous active-low reset
//   push/push_data : write an entry (dropped when full without a pop)
//   pop            : retire the head entry
//   head           : current head entry (don't-care when empty)
//   empty/full     : occupancy flags
//   occupancy      : number of stored entries, 0..p_depth
module regincr_resp_fifo
  import regincr_arb_pkg::*;
#(
  parameter  int unsigned p_depth    = 2,
  parameter  int unsigned p_bitwidth = 8,
  localparam int unsigned OW         = $clog2(p_depth + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [p_bitwidth-1:0] push_data,
  input  logic                  pop,
  output logic [p_bitwidth-1:0] head,
  output logic                  empty,
  output logic                  full,
  output logic [OW-1:0]         occupancy
);

  localparam int unsigned PW = ptr_width(p_depth);

  logic [p_bitwidth-1:0] mem [p_depth];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [OW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == OW'(p_depth));
  assign occupancy = count;
  assign head      = mem[rd_ptr];

  // A pop frees the head slot in the same edge, so push is allowed when full.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      count <= count + OW'(do_push) - OW'(do_pop);
    end
  end

  // Storage needs no reset; empty entries are never presented.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regincr_pipe_arbiter.sv
// Round-robin scheduler sharing one p_nstages-deep +1 pipeline between two
// val/rdy requesters; results return on per-requester response ports.
//   clk, reset   : clock, asynchronous active-low reset
//   req0, req1   : request channels (operand in)
//   resp0, resp1 : response channels (operand + p_nstages out)
module regincr_pipe_arbiter
  import regincr_arb_pkg::*;
#(
  parameter int unsigned p_nstages  = 2,
  parameter int unsigned p_bitwidth = 8,
  parameter int unsigned p_depth    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  regincr_pipe_arbiter_if.slave  req0,
  regincr_pipe_arbiter_if.slave  req1,
  regincr_pipe_arbiter_if.master resp0,
  regincr_pipe_arbiter_if.master resp1
);

  localparam int unsigned DW = p_bitwidth;
  localparam int unsigned CW = $clog2(p_depth + 1);

  typedef struct packed {
    logic            valid;
    reqid_t          tag;
    logic [DW-1:0]   data;
  } slot_t;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant_rdy;
  logic [NUM_REQ-1:0] issue;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] wb_push;
  logic [NUM_REQ-1:0] fifo_empty;
  logic [NUM_REQ-1:0] fifo_full;
  logic [CW-1:0]      fifo_occ [NUM_REQ];
  reqid_t             ptr;
  reqid_t             grant_id;
  logic [DW-1:0]      issue_msg;
  slot_t              last;

  // Round-robin grant; a requester's rdy never looks at its own val.
  assign grant_rdy[0] = elig[0] & (~req1.val | ~elig[1] | (ptr == REQ0));
  assign grant_rdy[1] = elig[1] & (~req0.val | ~elig[0] | (ptr == REQ1));
  assign req0.rdy     = grant_rdy[0];
  assign req1.rdy     = grant_rdy[1];

  assign issue[0]  = req0.val & grant_rdy[0];
  assign issue[1]  = req1.val & grant_rdy[1];
  assign pop[0]    = resp0.val & resp0.rdy;
  assign pop[1]    = resp1.val & resp1.rdy;
  assign grant_id  = issue[1] ? REQ1 : REQ0;
  assign issue_msg = issue[1] ? req1.msg : req0.msg;

  // Priority flips to the other requester after each grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ptr <= REQ0;
    else if (issue[0]) ptr <= REQ1;
    else if (issue[1]) ptr <= REQ0;
  end

  // Credits cover both buffered and in-flight results, so no push can overflow.
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_credit
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 cnt <= '0;
      else if (issue[i] && !pop[i]) cnt <= cnt + CW'(1);
      else if (!issue[i] && pop[i]) cnt <= cnt - CW'(1);
    end

    // Gated by reset so rdy is low while reset is held.
    assign elig[i] = reset & (cnt < CW'(p_depth));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(wb_push[i] && fifo_full[i] && !pop[i]));
    a_credit_covers: assert property (@(posedge clk) disable iff (!reset)
      fifo_occ[i] <= cnt);
  end

  // Stage k+1 holds operand + k + 1; only the valid bits are reset.
  for (genvar k = 0; k < int'(p_nstages); k++) begin : g_stage
    logic          valid;
    reqid_t        tag;
    logic [DW-1:0] data;
    logic          in_valid;
    reqid_t        in_tag;
    logic [DW-1:0] in_data;

    if (k == 0) begin : g_src
      assign in_valid = |issue;
      assign in_tag   = grant_id;
      assign in_data  = issue_msg;
    end else begin : g_src
      assign in_valid = g_stage[k-1].valid;
      assign in_tag   = g_stage[k-1].tag;
      assign in_data  = g_stage[k-1].data;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) valid <= 1'b0;
      else        valid <= in_valid;
    end

    always_ff @(posedge clk) begin
      tag  <= in_tag;
      data <= in_data + DW'(1);
    end
  end

  assign last = '{valid: g_stage[p_nstages-1].valid,
                  tag:   g_stage[p_nstages-1].tag,
                  data:  g_stage[p_nstages-1].data};

  // Writeback demux by tag.
  assign wb_push[0] = last.valid & (last.tag == REQ0);
  assign wb_push[1] = last.valid & (last.tag == REQ1);

  regincr_resp_fifo #(.p_depth(p_depth), .p_bitwidth(DW)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (wb_push[0]),
    .push_data (last.data),
    .pop       (pop[0]),
    .head      (resp0.msg),
    .empty     (fifo_empty[0]),
    .full      (fifo_full[0]),
    .occupancy (fifo_occ[0])
  );

  regincr_resp_fifo #(.p_depth(p_depth), .p_bitwidth(DW)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (wb_push[1]),
    .push_data (last.data),
    .pop       (pop[1]),
    .head      (resp1.msg),
    .empty     (fifo_empty[1]),
    .full      (fifo_full[1]),
    .occupancy (fifo_occ[1])
  );

  assign resp0.val = ~fifo_empty[0];
  assign resp1.val = ~fifo_empty[1];

endmodule

// File: tb/tb_regincr_pipe_arbiter.sv
// Randomised/directed bench for regincr_pipe_arbiter with a scoreboard and a
// transaction-level reference model (credits, pointer, per-requester queues).
module tb_regincr_pipe_arbiter;

  localparam int NST = 2;
  localparam int BW  = 8;
  localparam int DEP = 2;

  typedef struct {
    logic [BW-1:0] data;
    int            ready;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regincr_pipe_arbiter_if #(.p_bitwidth(BW)) req0 ();
  regincr_pipe_arbiter_if #(.p_bitwidth(BW)) req1 ();
  regincr_pipe_arbiter_if #(.p_bitwidth(BW)) resp0 ();
  regincr_pipe_arbiter_if #(.p_bitwidth(BW)) resp1 ();

  regincr_pipe_arbiter #(.p_nstages(NST), .p_bitwidth(BW), .p_depth(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .resp0 (resp0),
    .resp1 (resp1)
  );

  exp_t sb [2][$];
  int   credit_m [2];
  bit   ptr_m;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares rdy against the arbitration rule and responses against
  // the scoreboard head, then advances the model by the transfers of this cycle.
  always @(negedge clk) begin : mon
    bit er0, er1, ev;
    logic dval, drdy;
    logic [BW-1:0] dmsg;
    if (!reset) begin
      check("reset_req0_rdy", 32'(req0.rdy), 0);
      check("reset_req1_rdy", 32'(req1.rdy), 0);
      check("reset_resp0_val", 32'(resp0.val), 0);
      check("reset_resp1_val", 32'(resp1.val), 0);
    end else begin
      er0 = (credit_m[0] < DEP) && (!req1.val || !(credit_m[1] < DEP) || !ptr_m);
      er1 = (credit_m[1] < DEP) && (!req0.val || !(credit_m[0] < DEP) || ptr_m);
      check("req0_rdy", 32'(req0.rdy), 32'(er0));
      check("req1_rdy", 32'(req1.rdy), 32'(er1));
      for (int i = 0; i < 2; i++) begin
        dval = (i == 0) ? resp0.val : resp1.val;
        drdy = (i == 0) ? resp0.rdy : resp1.rdy;
        dmsg = (i == 0) ? resp0.msg : resp1.msg;
        ev = (sb[i].size() > 0) && (sb[i][0].ready <= cyc);
        check((i == 0) ? "resp0_val" : "resp1_val", 32'(dval), 32'(ev));
        if (ev) begin
          check((i == 0) ? "resp0_msg" : "resp1_msg", 32'(dmsg), 32'(sb[i][0].data));
          if (drdy) begin
            sb[i].delete(0);
            credit_m[i]--;
          end
        end
      end
      if (req0.val && er0) begin
        credit_m[0]++;
        ptr_m = 1'b1;
      end else if (req1.val && er1) begin
        credit_m[1]++;
        ptr_m = 1'b0;
      end
    end
  end

  // Drive one cycle (called at posedge+1); accepted requests go to the scoreboard.
  task automatic step(input bit v0, input logic [BW-1:0] m0, input bit v1,
                      input logic [BW-1:0] m1, input bit r0, input bit r1,
                      output bit a0, output bit a1);
    exp_t e;
    req0.val  = v0;
    req0.msg  = m0;
    req1.val  = v1;
    req1.msg  = m1;
    resp0.rdy = r0;
    resp1.rdy = r1;
    #3;
    a0 = (req0.val === 1'b1) && (req0.rdy === 1'b1);
    a1 = (req1.val === 1'b1) && (req1.rdy === 1'b1);
    if (a0) begin
      e.data  = req0.msg + BW'(NST);
      e.ready = cyc + 1 + NST;
      sb[0].push_back(e);
    end
    if (a1) begin
      e.data  = req1.msg + BW'(NST);
      e.ready = cyc + 1 + NST;
      sb[1].push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a0, a1;
    repeat (n) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, a0, a1);
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b0;
    req0.val  = 1'b0;
    req1.val  = 1'b0;
    sb[0].delete();
    sb[1].delete();
    credit_m[0] = 0;
    credit_m[1] = 0;
    ptr_m = 1'b0;
    #1;
    check("rst_now_req0_rdy", 32'(req0.rdy), 0);
    check("rst_now_req1_rdy", 32'(req1.rdy), 0);
    check("rst_now_resp0_val", 32'(resp0.val), 0);
    check("rst_now_resp1_val", 32'(resp1.val), 0);
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    bit a0, a1;
    logic [BW-1:0] op0, op1;
    int n1;
    req0.val = 1'b0; req0.msg = '0; req1.val = 1'b0; req1.msg = '0;
    resp0.rdy = 1'b1; resp1.rdy = 1'b1;
    @(posedge clk);
    #1;
    do_reset(3);

    // Single request on requester 0.
    step(1'b1, 8'h10, 1'b0, '0, 1'b1, 1'b1, a0, a1);
    check("single_accept", 32'(a0), 1);
    idle(6);

    // Contention: alternating grants from a fresh pointer.
    do_reset(2);
    op0 = 8'h00;
    op1 = 8'h80;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, op0, 1'b1, op1, 1'b1, 1'b1, a0, a1);
      if (k < 4) check("cont_grant", {30'b0, a0, a1}, (k % 2 == 0) ? 32'h2 : 32'h1);
      if (a0) op0++;
      if (a1) op1++;
    end
    idle(6);

    // Backpressure on requester 1: only p_depth requests accepted.
    n1 = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, op0, 1'b1, op1, 1'b1, 1'b0, a0, a1);
      if (a0) op0++;
      if (a1) begin op1++; n1++; end
    end
    check("bp_req1_accepts", 32'(n1), DEP);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, op0, 1'b1, op1, 1'b1, 1'b1, a0, a1);
      if (a1) op1++;
    end
    idle(6);

    // Wrap-around.
    step(1'b1, 8'hFE, 1'b0, '0, 1'b1, 1'b1, a0, a1);
    check("wrap_fe_accept", 32'(a0), 1);
    step(1'b1, 8'hFF, 1'b0, '0, 1'b1, 1'b1, a0, a1);
    check("wrap_ff_accept", 32'(a0), 1);
    idle(6);

    // Fill requester 0's buffer, then drain while still issuing.
    for (int k = 0; k < 6; k++) step(1'b1, 8'(8'h40 + k), 1'b0, '0, 1'b0, 1'b1, a0, a1);
    for (int k = 0; k < 10; k++) step(1'b1, 8'(8'h50 + k), 1'b0, '0, 1'b1, 1'b1, a0, a1);
    idle(6);

    // Randomised traffic and backpressure.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a0, a1);
    end
    idle(8);
    check("drain0_empty", 32'(sb[0].size()), 0);
    check("drain1_empty", 32'(sb[1].size()), 0);

    // Reset with one result buffered and two in flight.
    step(1'b1, 8'h30, 1'b0, '0, 1'b0, 1'b0, a0, a1);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, a0, a1);
    step(1'b0, '0, 1'b1, 8'h60, 1'b0, 1'b0, a0, a1);
    step(1'b0, '0, 1'b1, 8'h61, 1'b0, 1'b0, a0, a1);
    do_reset(2);
    idle(6);
    step(1'b1, 8'h05, 1'b0, '0, 1'b1, 1'b1, a0, a1);
    check("post_reset_accept", 32'(a0), 1);
    idle(6);
    check("final0_empty", 32'(sb[0].size()), 0);
    check("final1_empty", 32'(sb[1].size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
